rot_frame_timing_gen: RTL

Output-side frame timing generator for the rotated image path. Consumes the output frame width/depth produced by the width/depth calculation stage (12-bit, nominally 1024×768). Generates the frame sync, line sync, data-enable and pixel coordinates that drive the rotated-image read/inverse-mapping logic. One frame per start request; dimensions are latched at frame start and held for the whole frame.

---
 rtl/rot_frame_timing_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rot_frame_timing_gen.sv
// -----------------------------------------------------------------------------
// rot_frame_timing_gen
//
// Output-side frame timing generator for the rotated image path. On a start
// request in IDLE it latches the (clamped) frame width/depth and produces one
// frame of timing: a vertical blanking interval with a frame-start pulse, then
// per line a horizontal blanking interval with a line-start pulse followed by
// W active pixels with their column/line coordinates, and finally a one-cycle
// end-of-frame pulse.
//
// Ports:
//   i_clk     system clock, all logic on the rising edge
//   i_reset   synchronous active-high reset
//   i_start   frame request, only honoured in IDLE with non-zero dimensions
//   iv_width  requested frame width in pixels (clamped to MAX_WIDTH)
//   iv_depth  requested frame depth in lines  (clamped to MAX_DEPTH)
//   o_fsyn    one-cycle frame-start pulse (first VBLANK cycle)
//   o_hsyn    one-cycle line-start pulse (first HBLANK cycle of each line)
//   o_de      active pixel valid
//   ov_x      pixel column 0..W-1 (0 when o_de is low)
//   ov_y      pixel line 0..D-1   (0 when o_de is low)
//   o_busy    frame in progress (VBLANK, HBLANK, ACTIVE, DONE)
//   o_done    one-cycle end-of-frame pulse
//
// All outputs are registered and decoded from the next-state values, so an
// accepted start at cycle T shows o_fsyn/o_busy at T+1.
// -----------------------------------------------------------------------------
module rot_frame_timing_gen #(
    parameter int F_BLANK   = 4,
    parameter int H_BLANK   = 16,
    parameter int MAX_WIDTH = 1024,
    parameter int MAX_DEPTH = 768
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [11:0] iv_width,
    input  logic [11:0] iv_depth,
    output logic        o_fsyn,
    output logic        o_hsyn,
    output logic        o_de,
    output logic [11:0] ov_x,
    output logic [11:0] ov_y,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VBLANK = 3'd1,
        ST_HBLANK = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] F_LAST = 16'(F_BLANK - 1);
    localparam logic [15:0] H_LAST = 16'(H_BLANK - 1);
    localparam logic [11:0] MAX_W  = 12'(MAX_WIDTH);
    localparam logic [11:0] MAX_D  = 12'(MAX_DEPTH);

    state_t      state_r;
    state_t      state_s;
    logic [15:0] blank_cnt_r;
    logic [15:0] blank_cnt_s;
    logic [11:0] x_r;
    logic [11:0] x_s;
    logic [11:0] y_r;
    logic [11:0] y_s;
    logic [11:0] width_r;
    logic [11:0] width_s;
    logic [11:0] depth_r;
    logic [11:0] depth_s;

    logic        fsyn_r;
    logic        hsyn_r;
    logic        de_r;
    logic [11:0] x_out_r;
    logic [11:0] y_out_r;
    logic        busy_r;
    logic        done_r;

    // Next-state, counter and dimension-latch logic of the frame FSM.
    always_comb begin
        state_s     = state_r;
        blank_cnt_s = blank_cnt_r;
        x_s         = x_r;
        y_s         = y_r;
        width_s     = width_r;
        depth_s     = depth_r;
        case (state_r)
            ST_IDLE: begin
                // Zero-sized requests are dropped silently.
                if (i_start && (iv_width != 12'd0) && (iv_depth != 12'd0)) begin
                    state_s     = ST_VBLANK;
                    blank_cnt_s = 16'd0;
                    x_s         = 12'd0;
                    y_s         = 12'd0;
                    width_s     = (iv_width > MAX_W) ? MAX_W : iv_width;
                    depth_s     = (iv_depth > MAX_D) ? MAX_D : iv_depth;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VBLANK: begin
                if (blank_cnt_r == F_LAST) begin
                    state_s     = ST_HBLANK;
                    blank_cnt_s = 16'd0;
                    y_s         = 12'd0;
                end else begin
                    blank_cnt_s = blank_cnt_r + 16'd1;
                end
            end
            ST_HBLANK: begin
                if (blank_cnt_r == H_LAST) begin
                    state_s = ST_ACTIVE;
                    x_s     = 12'd0;
                end else begin
                    blank_cnt_s = blank_cnt_r + 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (x_r == (width_r - 12'd1)) begin
                    x_s = 12'd0;
                    if (y_r == (depth_r - 12'd1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s     = ST_HBLANK;
                        blank_cnt_s = 16'd0;
                        y_s         = y_r + 12'd1;
                    end
                end else begin
                    x_s = x_r + 12'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and latched dimensions.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            blank_cnt_r <= 16'd0;
            x_r         <= 12'd0;
            y_r         <= 12'd0;
            width_r     <= 12'd0;
            depth_r     <= 12'd0;
        end else begin
            state_r     <= state_s;
            blank_cnt_r <= blank_cnt_s;
            x_r         <= x_s;
            y_r         <= y_s;
            width_r     <= width_s;
            depth_r     <= depth_s;
        end
    end

    // Output registers decoded from the next state; blank counters only read
    // zero on the first cycle of a blanking interval, which gives the pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fsyn_r  <= 1'b0;
            hsyn_r  <= 1'b0;
            de_r    <= 1'b0;
            x_out_r <= 12'd0;
            y_out_r <= 12'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            fsyn_r  <= (state_s == ST_VBLANK) && (blank_cnt_s == 16'd0);
            hsyn_r  <= (state_s == ST_HBLANK) && (blank_cnt_s == 16'd0);
            de_r    <= (state_s == ST_ACTIVE);
            x_out_r <= (state_s == ST_ACTIVE) ? x_s : 12'd0;
            y_out_r <= (state_s == ST_ACTIVE) ? y_s : 12'd0;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign o_fsyn = fsyn_r;
    assign o_hsyn = hsyn_r;
    assign o_de   = de_r;
    assign ov_x   = x_out_r;
    assign ov_y   = y_out_r;
    assign o_busy = busy_r;
    assign o_done = done_r;

endmodule
